// File: rtl/calc_result_formatter.sv
// calc_result_formatter: computes A op B on 4-bit unsigned operands using
// multi-cycle shift-add multiply and restoring divide, then converts the
// result to sign-magnitude BCD display nibbles for the seven-segment scanner.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : one-cycle request, sampled only while idle
//   code           : {A[3:0], B[3:0], op[1:0]}; op 00 add, 01 sub, 10 mul, 11 div
//   digits         : {d3,d2,d1,d0}; 0-9 digit, A minus, E error, F blank
//   busy           : high while an operation is in flight
//   done           : one-cycle pulse when digits is updated
module calc_result_formatter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  code,
    output logic [15:0] digits,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        BCD,
        FORMAT,
        FINISH
    } state_t;

    state_t      state;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [1:0]  op;
    logic [2:0]  cnt;
    logic [7:0]  acc;
    logic [7:0]  mcand;
    logic [3:0]  mplr;
    logic [3:0]  quo;
    logic [3:0]  rem;
    logic        neg;
    logic        err;
    logic [19:0] dd;
    logic [15:0] fmt;

    logic [4:0]  rem_trial;
    logic        rem_ge;
    logic [3:0]  rem_sub;
    logic [3:0]  quo_nx;
    logic [7:0]  acc_mul;
    logic [7:0]  mag_nx;
    logic [19:0] dd_adj;
    logic [19:0] dd_next;
    logic [3:0]  sgn;
    logic [15:0] fmt_c;

    function automatic logic [3:0] fix(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Restoring divide: the dividend bits are shifted out of the top of quo
    // while quotient bits enter at the bottom.
    always_comb begin
        rem_trial = {rem, quo[3]};
        rem_ge    = rem_trial >= {1'b0, b};
        rem_sub   = rem_trial[3:0] - b;
        quo_nx    = {quo[2:0], rem_ge};
        acc_mul   = mplr[0] ? acc + mcand : acc;
        if (op == 2'b11)
            mag_nx = {4'b0, quo_nx};
        else if (op == 2'b10)
            mag_nx = acc_mul;
        else
            mag_nx = acc;
    end

    // Double-dabble step: correct BCD nibbles, then shift left.
    always_comb begin
        dd_adj  = {fix(dd[19:16]), fix(dd[15:12]), fix(dd[11:8]), dd[7:0]};
        dd_next = dd_adj << 1;
    end

    // Right-justified display word with leading blanks and sign placement.
    always_comb begin
        sgn = neg ? 4'hA : 4'hF;
        if (err)
            fmt_c = 16'hFFFE;
        else if (dd[19:16] != 4'd0)
            fmt_c = {sgn, dd[19:16], dd[15:12], dd[11:8]};
        else if (dd[15:12] != 4'd0)
            fmt_c = {4'hF, sgn, dd[15:12], dd[11:8]};
        else
            fmt_c = {8'hFF, sgn, dd[11:8]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a      <= 4'd0;
            b      <= 4'd0;
            op     <= 2'd0;
            cnt    <= 3'd0;
            acc    <= 8'd0;
            mcand  <= 8'd0;
            mplr   <= 4'd0;
            quo    <= 4'd0;
            rem    <= 4'd0;
            neg    <= 1'b0;
            err    <= 1'b0;
            dd     <= 20'd0;
            fmt    <= 16'hFFFF;
            digits <= 16'hFFFF;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a     <= code[9:6];
                        b     <= code[5:2];
                        op    <= code[1:0];
                        cnt   <= 3'd0;
                        acc   <= 8'd0;
                        mcand <= {4'b0, code[9:6]};
                        mplr  <= code[5:2];
                        quo   <= code[9:6];
                        rem   <= 4'd0;
                        neg   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    cnt <= cnt + 3'd1;
                    unique case (op)
                        2'b00: begin
                            if (cnt == 3'd0)
                                acc <= {4'b0, a} + {4'b0, b};
                        end
                        2'b01: begin
                            if (cnt == 3'd0) begin
                                if (a >= b) begin
                                    acc <= {4'b0, a - b};
                                end else begin
                                    acc <= {4'b0, b - a};
                                    neg <= 1'b1;
                                end
                            end
                        end
                        2'b10: begin
                            acc   <= acc_mul;
                            mcand <= mcand << 1;
                            mplr  <= mplr >> 1;
                        end
                        2'b11: begin
                            if (b == 4'd0)
                                err <= 1'b1;
                            quo <= quo_nx;
                            rem <= rem_ge ? rem_sub : rem_trial[3:0];
                        end
                        default: ;
                    endcase
                    if (cnt == 3'd3) begin
                        cnt   <= 3'd0;
                        dd    <= {12'd0, mag_nx};
                        state <= BCD;
                    end
                end
                BCD: begin
                    dd  <= dd_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= FORMAT;
                end
                FORMAT: begin
                    fmt   <= fmt_c;
                    state <= FINISH;
                end
                FINISH: begin
                    digits <= fmt;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_result_formatter.sv
// tb_calc_result_formatter: directed and randomized checks of
// calc_result_formatter against an arithmetic reference model.
module tb_calc_result_formatter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  code;
    logic [15:0] digits;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    calc_result_formatter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .code    (code),
        .digits  (digits),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [15:0] model(input logic [9:0] c);
        int a;
        int b;
        int r;
        int m;
        int pos;
        logic [15:0] d;
        a = int'(c[9:6]);
        b = int'(c[5:2]);
        case (c[1:0])
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: r = a * b;
            default: begin
                if (b == 0)
                    return 16'hFFFE;
                r = a / b;
            end
        endcase
        m = (r < 0) ? -r : r;
        d = 16'hFFFF;
        pos = 0;
        do begin
            d[pos*4 +: 4] = 4'(m % 10);
            m = m / 10;
            pos++;
        end while (m > 0);
        if (r < 0)
            d[pos*4 +: 4] = 4'hA;
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic launch(input logic [9:0] c);
        start = 1'b1;
        code  = c;
        @(negedge clock);
        start = 1'b0;
        code  = 10'($urandom);
    endtask

    task automatic finish_op(input string tag, input logic [15:0] exp,
                             input bit inj, input logic [9:0] inj_code);
        int n;
        int bc;
        n = 0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy)
                bc++;
            n++;
            if (inj && n == 5) begin
                start = 1'b1;
                code  = inj_code;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check({tag, " latency"}, n, 14);
        check({tag, " busy_cycles"}, bc, 14);
        check({tag, " busy_at_done"}, {31'd0, busy}, 0);
        check({tag, " digits"}, {16'd0, digits}, {16'd0, exp});
    endtask

    task automatic do_op(input string tag, input logic [9:0] c,
                         input logic [15:0] exp);
        launch(c);
        finish_op(tag, exp, 1'b0, 10'd0);
        @(negedge clock);
        check({tag, " done_pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        logic [9:0] c;
        int extra;

        reset_n = 1'b0;
        start   = 1'b0;
        code    = 10'd0;
        repeat (3) @(negedge clock);
        check("rst digits", {16'd0, digits}, 32'hFFFF);
        check("rst busy", {31'd0, busy}, 0);
        check("rst done", {31'd0, done}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        do_op("add 9+7", {4'd9, 4'd7, 2'b00}, 16'hFF16);
        do_op("sub 3-12", {4'd3, 4'd12, 2'b01}, 16'hFFA9);
        do_op("sub 5-5", {4'd5, 4'd5, 2'b01}, 16'hFFF0);
        do_op("sub 15-0", {4'd15, 4'd0, 2'b01}, 16'hFF15);
        do_op("mul 15x15", {4'd15, 4'd15, 2'b10}, 16'hF225);
        do_op("mul 0x9", {4'd0, 4'd9, 2'b10}, 16'hFFF0);
        do_op("mul 4x3", {4'd4, 4'd3, 2'b10}, 16'hFF12);
        do_op("div 13/4", {4'd13, 4'd4, 2'b11}, 16'hFFF3);
        do_op("div 15/1", {4'd15, 4'd1, 2'b11}, 16'hFF15);
        do_op("div 7/0", {4'd7, 4'd0, 2'b11}, 16'hFFFE);

        repeat (5) @(negedge clock);
        check("digits hold", {16'd0, digits}, 32'hFFFE);

        // start during busy must be ignored
        launch({4'd6, 4'd7, 2'b10});
        finish_op("ignore", 16'hFF42, 1'b1, {4'd1, 4'd1, 2'b00});
        extra = 0;
        repeat (20) begin
            @(negedge clock);
            if (done)
                extra++;
        end
        check("ignore extra_done", extra, 0);
        check("ignore hold", {16'd0, digits}, 32'hFF42);

        // back-to-back: start in the done cycle
        launch({4'd12, 4'd9, 2'b01});
        finish_op("b2b first", 16'hFFF3, 1'b0, 10'd0);
        launch({4'd2, 4'd11, 2'b10});
        finish_op("b2b second", 16'hFF22, 1'b0, 10'd0);
        @(negedge clock);
        check("b2b done_pulse", {31'd0, done}, 0);

        // reset during BCD phase
        launch({4'd14, 4'd13, 2'b10});
        repeat (7) @(negedge clock);
        check("mid busy", {31'd0, busy}, 1);
        reset_n = 1'b0;
        #1;
        check("mid rst busy", {31'd0, busy}, 0);
        check("mid rst done", {31'd0, done}, 0);
        check("mid rst digits", {16'd0, digits}, 32'hFFFF);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("mid rst idle digits", {16'd0, digits}, 32'hFFFF);
        do_op("after rst", {4'd8, 4'd3, 2'b11}, 16'hFFF2);

        for (int i = 0; i < 24; i++) begin
            c = 10'($urandom);
            do_op($sformatf("rand %0d code %0h", i, c), c, model(c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
